// File: rtl/hash_table_pkg.sv
// Package: hash_table
// Shared sizing and types for the hash-table free-pointer allocator.
//   TABLE_ADDR_WIDTH : width of a table address; the table holds TABLE_SIZE entries
//   FREE_CNT_WIDTH   : width of a count that must represent 0..TABLE_SIZE inclusive
//   alloc_state_e    : allocator FSM states (INIT fills the list, LOAD primes output)
package hash_table;

  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int TABLE_SIZE       = 2 ** TABLE_ADDR_WIDTH;
  localparam int FREE_CNT_WIDTH   = TABLE_ADDR_WIDTH + 1;

  typedef logic [TABLE_ADDR_WIDTH-1:0] table_addr_t;
  typedef logic [FREE_CNT_WIDTH-1:0]   free_cnt_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } alloc_state_e;

endpackage

// File: rtl/free_ptr_ram.sv
// Module: free_ptr_ram
// Storage for the free-address FIFO: simple dual-port, TABLE_SIZE x TABLE_ADDR_WIDTH,
// one write port and one read port with a registered (1-cycle) read. No reset and no
// write-to-read bypass; a same-cycle read of the written location returns old data.
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address, sampled every cycle
//   rd_data_o  : data at rd_addr_i from the previous cycle
module free_ptr_ram
  import hash_table::*;
(
  input  logic                        clk_i,
  input  logic                        wr_en_i,
  input  logic [TABLE_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [TABLE_ADDR_WIDTH-1:0] wr_data_i,
  input  logic [TABLE_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [TABLE_ADDR_WIDTH-1:0] rd_data_o
);

  table_addr_t mem [TABLE_SIZE];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/free_ptr_allocator.sv
// Module: free_ptr_allocator
// FIFO-ordered free list of hash-table addresses. After reset or srst_i it loads
// every address 0..N-1 (INIT), primes the show-ahead head (LOAD), then serves
// allocations and frees (READY). A bitmap tracks which addresses are free so that
// double frees are rejected.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   srst_i             : synchronous re-init request
//   add_addr_i/_en_i   : address being freed, one per cycle
//   alloc_rd_i         : pop strobe
//   alloc_addr_o/val_o : show-ahead head of the free list and its valid
//   ready_o            : init complete
//   free_cnt_o         : number of free addresses, 0..N
//   err_*_o            : one-cycle error pulses (double free, underflow, busy)
//   dbg_state_o        : FSM state, for observation only
//
// Handshake: alloc_addr_o is meaningful only while alloc_val_o=1; a cycle with
// alloc_val_o=1 and alloc_rd_i=1 consumes it and the next entry (if any) is shown
// on the following cycle. alloc_rd_i with alloc_val_o=0 is an underflow and has
// no effect. add_addr_en_i is accepted whenever ready_o=1 and the address is not
// already free; there is no backpressure on frees.
module free_ptr_allocator
  import hash_table::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        srst_i,
  input  logic [TABLE_ADDR_WIDTH-1:0] add_addr_i,
  input  logic                        add_addr_en_i,
  input  logic                        alloc_rd_i,
  output logic [TABLE_ADDR_WIDTH-1:0] alloc_addr_o,
  output logic                        alloc_val_o,
  output logic                        ready_o,
  output logic [FREE_CNT_WIDTH-1:0]   free_cnt_o,
  output logic                        err_dbl_free_o,
  output logic                        err_underflow_o,
  output logic                        err_busy_o,
  output alloc_state_e                dbg_state_o
);

  alloc_state_e state_q, state_d;

  table_addr_t            wr_ptr_q, rd_ptr_q;
  free_cnt_t              cnt_q;
  logic [TABLE_SIZE-1:0]  bitmap_q;
  logic                   byp_q;
  table_addr_t            byp_data_q;
  logic                   err_dbl_q, err_under_q, err_busy_q;

  logic                   wr_en, init_wr, add_ok, pop_ok;
  table_addr_t            wr_addr, wr_data, rd_addr, ram_rd_data, head;
  logic                   err_dbl_d, err_under_d, err_busy_d;

  free_ptr_ram u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rd_data)
  );

  // The RAM re-reads the head location every cycle. The only stale case is a
  // write landing on the very location being read in the same cycle (list empty,
  // or draining to empty while an add arrives); that value is captured here.
  assign head = byp_q ? byp_data_q : ram_rd_data;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    init_wr = 1'b0;
    add_ok  = 1'b0;
    pop_ok  = 1'b0;
    wr_addr = wr_ptr_q;
    wr_data = add_addr_i;
    rd_addr = rd_ptr_q;
    case (state_q)
      ST_INIT: begin
        // The write pointer doubles as the init counter: it writes its own value.
        init_wr = 1'b1;
        wr_en   = 1'b1;
        wr_data = wr_ptr_q;
        if (&wr_ptr_q) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_READY;
      end
      ST_READY: begin
        add_ok = add_addr_en_i && !bitmap_q[add_addr_i];
        pop_ok = alloc_rd_i && (cnt_q != '0);
        wr_en  = add_ok;
        // Read ahead so the next entry is visible the cycle after a pop.
        if (pop_ok) begin
          rd_addr = rd_ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    if (srst_i) begin
      state_d = ST_INIT;
      wr_en   = 1'b0;
      init_wr = 1'b0;
      add_ok  = 1'b0;
      pop_ok  = 1'b0;
    end
  end

  assign err_busy_d  = !srst_i && (state_q != ST_READY) && (add_addr_en_i || alloc_rd_i);
  assign err_under_d = !srst_i && (state_q == ST_READY) && alloc_rd_i && (cnt_q == '0);
  assign err_dbl_d   = !srst_i && (state_q == ST_READY) && add_addr_en_i && bitmap_q[add_addr_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      bitmap_q    <= '0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
      err_dbl_q   <= 1'b0;
      err_under_q <= 1'b0;
      err_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_dbl_q   <= err_dbl_d;
      err_under_q <= err_under_d;
      err_busy_q  <= err_busy_d;
      byp_q       <= wr_en && (wr_addr == rd_addr);
      byp_data_q  <= wr_data;
      if (srst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        bitmap_q <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop_ok) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (pop_ok && !wr_en) begin
          cnt_q <= cnt_q - 1'b1;
        end
        if (init_wr) begin
          bitmap_q[wr_ptr_q] <= 1'b1;
        end
        if (add_ok) begin
          bitmap_q[add_addr_i] <= 1'b1;
        end
        // An accepted add never targets the head: the head's bit is set.
        if (pop_ok) begin
          bitmap_q[head] <= 1'b0;
        end
      end
    end
  end

  assign ready_o         = (state_q == ST_READY);
  assign alloc_val_o     = (state_q == ST_READY) && (cnt_q != '0);
  assign alloc_addr_o    = alloc_val_o ? head : '0;
  assign free_cnt_o      = cnt_q;
  assign err_dbl_free_o  = err_dbl_q;
  assign err_underflow_o = err_under_q;
  assign err_busy_o      = err_busy_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_free_ptr_allocator.sv
// Testbench for free_ptr_allocator (TABLE_ADDR_WIDTH=8, N=256).
module tb_free_ptr_allocator;
  import hash_table::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                      srst = 1'b0;
  logic [TABLE_ADDR_WIDTH-1:0] add_addr = '0;
  logic                      add_addr_en = 1'b0;
  logic                      alloc_rd = 1'b0;
  logic [TABLE_ADDR_WIDTH-1:0] alloc_addr;
  logic                      alloc_val, ready;
  logic [FREE_CNT_WIDTH-1:0] free_cnt;
  logic                      err_dbl, err_under, err_busy;
  alloc_state_e              dbg_state;

  free_ptr_allocator dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .srst_i          (srst),
    .add_addr_i      (add_addr),
    .add_addr_en_i   (add_addr_en),
    .alloc_rd_i      (alloc_rd),
    .alloc_addr_o    (alloc_addr),
    .alloc_val_o     (alloc_val),
    .ready_o         (ready),
    .free_cnt_o      (free_cnt),
    .err_dbl_free_o  (err_dbl),
    .err_underflow_o (err_under),
    .err_busy_o      (err_busy),
    .dbg_state_o     (dbg_state)
  );

  // scoreboard / model
  logic [7:0]   exp_q[$];
  logic [255:0] m_free = '0;
  logic         m_ready = 1'b0;
  logic [7:0]   last_pop = 8'h00;
  int           check_cnt = 0;
  int           err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ready = 1'b0;
    exp_q.delete();
    m_free = '0;
  endtask

  // One clock of stimulus; model updated from the pre-edge state, DUT checked after.
  task automatic do_cycle(input logic a_en, input logic [7:0] a, input logic p);
    logic exp_dbl, exp_under, exp_busy, add_ok, pop_ok;
    logic [7:0] popped;
    exp_dbl   = m_ready && a_en && m_free[a];
    exp_under = m_ready && p && (exp_q.size() == 0);
    exp_busy  = !m_ready && (a_en || p);
    add_ok    = m_ready && a_en && !m_free[a];
    pop_ok    = m_ready && p && (exp_q.size() != 0);
    if (pop_ok) begin
      popped = exp_q.pop_front();
      check("pop_addr", 32'(alloc_addr), 32'(popped));
      m_free[popped] = 1'b0;
      last_pop = popped;
    end
    if (add_ok) begin
      exp_q.push_back(a);
      m_free[a] = 1'b1;
    end
    add_addr_en = a_en;
    add_addr    = a;
    alloc_rd    = p;
    @(posedge clk); #1;
    add_addr_en = 1'b0;
    alloc_rd    = 1'b0;
    check("err_dbl_free", 32'(err_dbl), 32'(exp_dbl));
    check("err_underflow", 32'(err_under), 32'(exp_under));
    check("err_busy", 32'(err_busy), 32'(exp_busy));
    if (m_ready) begin
      check("free_cnt", 32'(free_cnt), exp_q.size());
      check("alloc_val", 32'(alloc_val), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("head_addr", 32'(alloc_addr), 32'(exp_q[0]));
    end
  endtask

  // Bounded wait for ready_o, then load the model with the init contents.
  task automatic wait_ready(input int exp_n);
    int n;
    n = 0;
    while (!ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_latency", n, exp_n);
    m_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    m_free = '1;
    check("ready_state", 32'(dbg_state), 32'(ST_READY));
    check("ready_cnt", 32'(free_cnt), 32'd256);
    check("ready_val", 32'(alloc_val), 32'd1);
    check("ready_addr", 32'(alloc_addr), 32'h00);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_val", 32'(alloc_val), 32'd0);
    check("rst_addr", 32'(alloc_addr), 32'd0);
    check("rst_cnt", 32'(free_cnt), 32'd0);
    check("rst_errs", {29'd0, err_dbl, err_under, err_busy}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_INIT));
    rst = 1'b0;
    wait_ready(257);

    // drain the whole list, then underflow
    for (int i = 0; i < 256; i++) do_cycle(1'b0, 8'h00, 1'b1);
    check("drained_cnt", 32'(free_cnt), 32'd0);
    do_cycle(1'b0, 8'h00, 1'b1);

    // add to empty list, then double free
    do_cycle(1'b1, 8'h3C, 1'b0);
    check("empty_add_addr", 32'(alloc_addr), 32'h3C);
    do_cycle(1'b1, 8'h3C, 1'b0);

    // ten free entries, add+pop each cycle
    for (int i = 0; i < 9; i++) do_cycle(1'b1, 8'(8'h10 + i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) check("fifo_order_05", 32'(alloc_addr), 32'h05);
      do_cycle(1'b1, (k == 0) ? 8'h05 : last_pop, 1'b1);
      check("steady_cnt", 32'(free_cnt), 32'd10);
    end

    // srst mid-traffic with same-cycle add and pop
    srst = 1'b1; add_addr_en = 1'b1; add_addr = 8'hA0; alloc_rd = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0; add_addr_en = 1'b0; alloc_rd = 1'b0;
    check("srst_errs", {29'd0, err_dbl, err_under, err_busy}, 32'd0);
    check("srst_ready", 32'(ready), 32'd0);
    check("srst_val", 32'(alloc_val), 32'd0);
    check("srst_cnt", 32'(free_cnt), 32'd0);
    model_clear();
    wait_ready(257);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 8'h00, 1'b1);

    // add during INIT
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    model_clear();
    do_cycle(1'b1, 8'h77, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0);
    wait_ready(255);
    do_cycle(1'b1, 8'h77, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
